inst_mem_model: RTL and testbench

//   Word-addressed main-memory model sitting directly downstream of the I-cache miss path.

---
 rtl/inst_mem_model.sv | 95 +++++++++
 tb/tb_inst_mem_model.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_model.sv
// Word-addressed 32-bit memory model for the I-cache miss path: one request at a time,
// answered after LATENCY edges with a single-cycle ready pulse.
module inst_mem_model #(
    parameter int    ADDR_W    = 10,
    parameter int    LATENCY   = 4,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_valid,
    input  logic        mem_req_wr,
    input  logic [31:0] mem_req_addr,
    input  logic [31:0] mem_wr_data,
    output logic [31:0] mem_req_data,
    output logic        mem_req_ready,
    output logic        mem_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("inst_mem_model: LATENCY must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_idx;
    logic [31:0]         r_wdata;
    logic [31:0]         r_mem [DEPTH];

    logic                w_done;
    logic                w_mem_we;
    logic                w_unused_addr;

    // Byte offset and aliased upper bits play no part in the word index.
    assign w_unused_addr = ^{mem_req_addr[31:ADDR_W+2], mem_req_addr[1:0]};

    // The access happens on the edge that moves WAIT into RESP (E0+LATENCY).
    assign w_done   = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_mem_we = w_done && r_wr && !rst;

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_idx] <= r_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_wr          <= 1'b0;
            r_idx         <= '0;
            r_wdata       <= 32'd0;
            mem_req_data  <= 32'd0;
            mem_req_ready <= 1'b0;
            mem_busy      <= 1'b0;
        end else begin
            mem_req_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mem_req_valid) begin
                        r_wr     <= mem_req_wr;
                        r_idx    <= mem_req_addr[ADDR_W+1:2];
                        r_wdata  <= mem_wr_data;
                        r_cnt    <= 4'(LATENCY - 1);
                        r_state  <= S_WAIT;
                        mem_busy <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_done) begin
                        r_state       <= S_RESP;
                        mem_req_ready <= 1'b1;
                        if (!r_wr) mem_req_data <= r_mem[r_idx];
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state  <= S_IDLE;
                    mem_busy <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    mem_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_model.sv
// Bench for inst_mem_model: vector table, hand-written corner sequences and randomized
// traffic against an array reference model; LATENCY=4 and LATENCY=1 instances share inputs.
module tb_inst_mem_model;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] wr_data;
    logic [31:0] data4, data1;
    logic        ready4, ready1;
    logic        busy4, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_mem_model #(.ADDR_W(10), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .mem_req_valid(valid), .mem_req_wr(req_wr),
        .mem_req_addr(req_addr), .mem_wr_data(wr_data),
        .mem_req_data(data4), .mem_req_ready(ready4), .mem_busy(busy4)
    );

    inst_mem_model #(.ADDR_W(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .mem_req_valid(valid), .mem_req_wr(req_wr),
        .mem_req_addr(req_addr), .mem_wr_data(wr_data),
        .mem_req_data(data1), .mem_req_ready(ready1), .mem_busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // One transaction on the LATENCY=4 instance; called and returning at a negedge.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input bit intf, output logic [31:0] rdata, output int lat);
        rdata = 'x;
        lat   = -1;
        valid = 1'b1; req_wr = wr; req_addr = addr; wr_data = wdata;
        step();
        if (intf) begin
            req_wr = 1'b0; req_addr = 32'h200; wr_data = 32'h0;
        end else begin
            valid = 1'b0;
        end
        for (int k = 0; k <= 20; k++) begin
            chk("busy_in_flight", {31'd0, busy4}, 32'd1);
            if (ready4) begin
                lat   = k;
                rdata = data4;
                break;
            end
            step();
        end
        valid = 1'b0;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no ready within 20 cycles, required one");
        end
        step();
        chk("ready_one_cycle", {31'd0, ready4}, 32'd0);
        chk("busy_after_resp", {31'd0, busy4}, 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs[12];
    logic [31:0] rd;
    int          lat;
    logic [31:0] model [int];
    logic [31:0] last_rd;
    int          pick [8];

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[1]  = '{1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 32'h0000_0103, 32'h0,         32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 32'h0000_1100, 32'h0,         32'hDEAD_BEEF};
        vecs[4]  = '{1'b1, 32'h0000_0200, 32'h1111_2222, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 32'h0000_0204, 32'h1234_5678, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b0, 32'h0000_0204, 32'h0,         32'h1234_5678};
        vecs[7]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 32'h1234_5678};
        vecs[8]  = '{1'b0, 32'hFFFF_F000, 32'h0,         32'hA5A5_A5A5};
        vecs[9]  = '{1'b1, 32'h0000_0010, 32'h0BAD_F00D, 32'hA5A5_A5A5};
        vecs[10] = '{1'b0, 32'h0000_0012, 32'h0,         32'h0BAD_F00D};
        vecs[11] = '{1'b0, 32'h0000_0200, 32'h0,         32'h1111_2222};

        valid = 1'b0; req_wr = 1'b0; req_addr = 32'h0; wr_data = 32'h0; rst = 1'b1;
        @(negedge clk);
        do_reset();
        chk("reset_ready4", {31'd0, ready4}, 32'd0);
        chk("reset_busy4",  {31'd0, busy4},  32'd0);
        chk("reset_data4",  data4,           32'd0);
        chk("reset_ready1", {31'd0, ready1}, 32'd0);
        chk("reset_busy1",  {31'd0, busy1},  32'd0);
        chk("reset_data1",  data1,           32'd0);

        // Vector table: latency, returned/held data, aliasing.
        foreach (vecs[i]) begin
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, rd, lat);
            chk($sformatf("vec%0d_latency", i), lat, 32'd4);
            chk($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
        end

        // Read data held for several idle cycles.
        run_txn(1'b0, 32'h100, 32'h0, 1'b0, rd, lat);
        repeat (3) step();
        chk("data_held", data4, 32'hDEAD_BEEF);

        // Inputs changing (and valid held) during WAIT/RESP do not disturb the write.
        run_txn(1'b1, 32'h300, 32'hCAFE_F00D, 1'b1, rd, lat);
        chk("intf_latency", lat, 32'd4);
        run_txn(1'b0, 32'h300, 32'h0, 1'b0, rd, lat);
        chk("intf_committed", rd, 32'hCAFE_F00D);
        run_txn(1'b0, 32'h200, 32'h0, 1'b0, rd, lat);
        chk("intf_untouched", rd, 32'h1111_2222);

        // Reset two edges after acceptance drops the write.
        valid = 1'b1; req_wr = 1'b1; req_addr = 32'h10; wr_data = 32'h55AA_55AA;
        step();
        valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy4}, 32'd0);
        chk("rst_data", data4, 32'd0);
        begin
            int pulses = 0;
            repeat (8) begin
                if (ready4) pulses++;
                step();
            end
            chk("rst_no_ready", pulses, 32'd0);
        end
        run_txn(1'b0, 32'h10, 32'h0, 1'b0, rd, lat);
        chk("rst_write_dropped", rd, 32'h0BAD_F00D);

        // LATENCY=1 with valid held high: one read per pulse, every third cycle.
        do_reset();
        valid = 1'b1; req_wr = 1'b0;
        for (int k = 0; k < 18; k++) begin
            req_addr = (k % 2) ? 32'h100 : 32'h204;
            step();
            chk($sformatf("l1_ready_k%0d", k), {31'd0, ready1}, {31'd0, (k % 3) == 1});
            chk($sformatf("l1_busy_k%0d", k), {31'd0, busy1}, {31'd0, (k % 3) != 2});
            if ((k % 3) == 1)
                chk($sformatf("l1_data_k%0d", k), data1,
                    ((k - 1) % 2) ? 32'hDEAD_BEEF : 32'h1234_5678);
        end
        valid = 1'b0;

        // Randomized traffic against an array model, with aliased addresses.
        do_reset();
        last_rd = 32'h0;
        for (int i = 0; i < 8; i++) begin
            pick[i] = int'($urandom_range(1023, 0));
            for (int j = 0; j < i; j++)
                if (pick[j] == pick[i]) pick[i] = (pick[i] + 1 + i) % 1024;
            model[pick[i]] = $urandom;
            run_txn(1'b1, {20'($urandom), 10'(pick[i]), 2'($urandom)}, model[pick[i]], 1'b0, rd, lat);
        end
        for (int n = 0; n < 40; n++) begin
            int          idx;
            logic        w;
            logic [31:0] wd;
            idx = pick[$urandom_range(7, 0)];
            w   = 1'($urandom);
            wd  = $urandom;
            run_txn(w, {20'($urandom), 10'(idx), 2'($urandom)}, wd, bit'($urandom), rd, lat);
            chk($sformatf("rnd%0d_latency", n), lat, 32'd4);
            if (w) begin
                chk($sformatf("rnd%0d_wr_data_held", n), rd, last_rd);
                model[idx] = wd;
            end else begin
                chk($sformatf("rnd%0d_rd_data", n), rd, model[idx]);
                last_rd = model[idx];
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the end, required completion");
        $fatal(1);
    end

endmodule
